// File: rtl/fp16_multiplier_if.sv
// fp16_multiplier_if: operand/result bundle for fp16_multiplier (in_valid, a, b -> result, out_valid)
interface fp16_multiplier_if;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        out_valid;
  modport master (output in_valid, a, b, input result, out_valid);
  modport slave (input in_valid, a, b, output result, out_valid);
endinterface

// File: rtl/fp16_multiplier.sv
// fp16_multiplier: binary16 a*b, RNE, flush-to-zero, 1-cycle registered (clk, rst, bus: in_valid/a/b -> result/out_valid)
module fp16_multiplier (
  input logic clk,
  input logic rst,
  fp16_multiplier_if.slave bus
);
  logic               w_s, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_nan, w_inf, w_zero;
  logic [21:0]        w_p;
  logic [9:0]         w_frac;
  logic               w_guard, w_sticky, w_rnd;
  logic [10:0]        w_fr;
  logic signed [7:0]  w_e, w_e2;
  logic [15:0]        w_res;
  logic [15:0]        r_result;
  logic               r_out_valid;
  assign w_s      = bus.a[15] ^ bus.b[15];
  assign w_a_nan  = &bus.a[14:10] & |bus.a[9:0];
  assign w_b_nan  = &bus.b[14:10] & |bus.b[9:0];
  assign w_a_inf  = &bus.a[14:10] & ~|bus.a[9:0];
  assign w_b_inf  = &bus.b[14:10] & ~|bus.b[9:0];
  // exp=0 covers both true zero and flushed subnormals
  assign w_a_zero = ~|bus.a[14:10];
  assign w_b_zero = ~|bus.b[14:10];
  assign w_nan    = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
  assign w_inf    = w_a_inf | w_b_inf;
  assign w_zero   = w_a_zero | w_b_zero;
  assign w_p      = {11'b0, 1'b1, bus.a[9:0]} * {11'b0, 1'b1, bus.b[9:0]};
  // product in [1,4): P[21] selects a one-bit normalising shift
  assign w_frac   = w_p[21] ? w_p[20:11] : w_p[19:10];
  assign w_guard  = w_p[21] ? w_p[10] : w_p[9];
  assign w_sticky = w_p[21] ? |w_p[9:0] : |w_p[8:0];
  assign w_rnd    = w_guard & (w_sticky | w_frac[0]);
  assign w_e      = $signed({3'b0, bus.a[14:10]}) + $signed({3'b0, bus.b[14:10]}) - 8'sd15 + $signed({7'b0, w_p[21]});
  assign w_fr     = {1'b0, w_frac} + {10'b0, w_rnd};
  assign w_e2     = w_e + $signed({7'b0, w_fr[10]});
  always_comb
    w_res = w_nan ? 16'h7E00 :
            w_inf ? {w_s, 5'h1F, 10'h0} :
            w_zero ? {w_s, 15'h0} :
            (w_e2 >= 8'sd31) ? {w_s, 5'h1F, 10'h0} :
            (w_e2 <= 8'sd0) ? {w_s, 15'h0} :
            {w_s, w_e2[4:0], w_fr[10] ? 10'h0 : w_fr[9:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= 16'h0000;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) r_result <= w_res;
    end
  end
  assign bus.result    = r_result;
  assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_fp16_multiplier.sv
// tb_fp16_multiplier: table-driven scoreboard bench for fp16_multiplier
module tb_fp16_multiplier;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
  } vec_t;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int failures = 0;
  logic mon = 0;
  logic exp_v = 0;
  logic exp_rst = 1;
  logic [15:0] held = 16'h0;
  logic [15:0] q[$];
  vec_t tv[23];
  fp16_multiplier_if bus();
  fp16_multiplier dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    exp_v   <= bus.in_valid && !rst;
    exp_rst <= rst;
  end
  always @(negedge clk) begin
    if (mon) begin
      logic [15:0] e;
      if (exp_rst) held = 16'h0;
      checks++;
      if (bus.out_valid !== exp_v) begin
        failures++;
        $display("FAIL out_valid: got %b want %b at %0t", bus.out_valid, exp_v, $time);
      end
      if (bus.out_valid === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        held = e;
      end
      checks++;
      if (bus.result !== held) begin
        failures++;
        $display("FAIL result: got %h want %h at %0t", bus.result, held, $time);
      end
    end
  end
  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r);
    bus.in_valid = 1;
    bus.a = a;
    bus.b = b;
    q.push_back(r);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    bus.in_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    tv = '{
      '{16'hB423, 16'h3815, 16'hB039},
      '{16'hB023, 16'h3815, 16'hAC39},
      '{16'h3C00, 16'h3C00, 16'h3C00},
      '{16'h4000, 16'h4200, 16'h4600},
      '{16'hC000, 16'h3800, 16'hBC00},
      '{16'h7BFF, 16'h7BFF, 16'h7C00},
      '{16'h7C00, 16'hC000, 16'hFC00},
      '{16'h7C00, 16'h0000, 16'h7E00},
      '{16'h0000, 16'h7C00, 16'h7E00},
      '{16'h7E00, 16'h3C00, 16'h7E00},
      '{16'h7C00, 16'h7C01, 16'h7E00},
      '{16'h8000, 16'h3C00, 16'h8000},
      '{16'h8000, 16'hC000, 16'h0000},
      '{16'h0400, 16'h0400, 16'h0000},
      '{16'h0001, 16'h7BFF, 16'h0000},
      '{16'h4000, 16'h7800, 16'h7C00},
      '{16'h3C00, 16'h7BFF, 16'h7BFF},
      '{16'h0400, 16'h3C00, 16'h0400},
      '{16'h0400, 16'h3800, 16'h0000},
      '{16'h3C03, 16'h3E00, 16'h3E04},
      '{16'h3C01, 16'h3E00, 16'h3E02},
      '{16'h3BFF, 16'h3BFF, 16'h3BFE},
      '{16'h7C00, 16'hFC00, 16'hFC00}
    };
    bus.in_valid = 0;
    bus.a = 0;
    bus.b = 0;
    repeat (2) @(posedge clk);
    #1;
    mon = 1;
    rst = 0;
    idle(1);
    foreach (tv[i]) apply(tv[i].a, tv[i].b, tv[i].r);
    idle(3);
    apply(16'h4000, 16'h4200, 16'h4600);
    apply(16'hC000, 16'h3800, 16'hBC00);
    apply(16'hB423, 16'h3815, 16'hB039);
    idle(2);
    apply(16'h3C00, 16'h3C00, 16'h3C00);
    idle(1);
    rst = 1;
    bus.in_valid = 1;
    bus.a = 16'h4000;
    bus.b = 16'h4000;
    @(posedge clk);
    #1;
    rst = 0;
    idle(3);
    mon = 0;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending results want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
